// File: rtl/wrarb_pkg.sv
// wrarb_pkg: shared types and sizing helpers for the FIFO write-port arbiter.
package wrarb_pkg;

    typedef enum logic {IDLE, BURST} wrarb_state_e;

    localparam int STAT_W = 16;

    function automatic int cnt_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/wrarb_rr_pick.sv
// wrarb_rr_pick: combinational round-robin picker, first set req at or after start (wrapping).
module wrarb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] index
);

    // Scan from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                found = 1'b1;
                index = IW'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of the async FIFO write port.
// WRARB_STATS_EN adds stat_clr/stat_beats saturating per-requester beat counters.
module fifo_wr_arbiter
    import wrarb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int IDW      = $clog2(NUM_REQ),
    localparam int CW       = cnt_w(MAX_BURST)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       full,
    output logic                       w_en,
    output logic [DATA_W-1:0]          data_in,
    output logic                       grant_valid,
`ifdef WRARB_STATS_EN
    output logic [IDW-1:0]             grant_id,
    input  logic                       stat_clr,
    output logic [NUM_REQ*STAT_W-1:0]  stat_beats
`else
    output logic [IDW-1:0]             grant_id
`endif
);

    wrarb_state_e   state, state_nx;
    logic [IDW-1:0] gnt, gnt_nx, last_gnt, last_nx, base, start, pick_idx;
    logic [CW-1:0]  beat_cnt, cnt_nx;
    logic           found, beat, term;

    assign base  = (state == IDLE) ? last_gnt : gnt;
    assign start = (base == IDW'(NUM_REQ - 1)) ? '0 : base + 1'b1;
    assign beat  = (state == BURST) && req_valid[gnt] && !full;
    assign term  = beat && (req_last[gnt] || beat_cnt == CW'(MAX_BURST - 1));

    wrarb_rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
        .req   (req_valid),
        .start (start),
        .found (found),
        .index (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= IDW'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            last_gnt <= last_nx;
            beat_cnt <= cnt_nx;
        end
    end

    // A terminating beat re-arbitrates in place so consecutive grants have no bubble.
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        last_nx  = last_gnt;
        cnt_nx   = beat_cnt;
        if (state == IDLE || term) begin
            state_nx = found ? BURST : IDLE;
            if (found) begin
                gnt_nx  = pick_idx;
                last_nx = pick_idx;
                cnt_nx  = '0;
            end
        end else if (!req_valid[gnt]) begin
            state_nx = IDLE;
        end else if (beat) begin
            cnt_nx = beat_cnt + 1'b1;
        end
    end

    always_comb begin
        w_en        = beat;
        data_in     = beat ? req_data[int'(gnt)*DATA_W +: DATA_W] : '0;
        req_ready   = beat ? (NUM_REQ'(1) << gnt) : '0;
        grant_valid = (state == BURST);
        grant_id    = (state == BURST) ? gnt : '0;
    end

`ifdef WRARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                stat_cnt[i] <= '0;
            else if (stat_clr)
                stat_cnt[i] <= '0;
            else if (req_ready[i] && stat_cnt[i] != '1)
                stat_cnt[i] <= stat_cnt[i] + 1'b1;
        end
        assign stat_beats[i*STAT_W +: STAT_W] = stat_cnt[i];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven directed checks of fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        full = 1'b0;
    logic        w_en;
    logic [7:0]  data_in;
    logic        grant_valid;
    logic [1:0]  grant_id;
`ifdef WRARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [63:0] stat_beats;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .full        (full),
        .w_en        (w_en),
        .data_in     (data_in),
        .grant_valid (grant_valid),
`ifdef WRARB_STATS_EN
        .grant_id    (grant_id),
        .stat_clr    (stat_clr),
        .stat_beats  (stat_beats)
`else
        .grant_id    (grant_id)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic [7:0] dat;
        logic       w_en;
        logic [7:0] data;
        logic [3:0] ready;
        logic       gv;
        logic [1:0] gid;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                                input logic f, input logic [7:0] d, input logic we,
                                input logic [7:0] ed, input logic [3:0] rdy,
                                input logic gv, input logic [1:0] gid);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.full = f; t.dat = d;
        t.w_en = we; t.data = ed; t.ready = rdy; t.gv = gv; t.gid = gid;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t tbl[$];
        logic [7:0] lane5c [4];
        lane5c = '{8'h5C, 8'h4C, 8'h7C, 8'h6C};

        // Req0 alone, 3-beat packet; re-granted once because it is the only valid requester.
        tbl.push_back(mk(1, 4'h1, 4'h0, 0, 8'hA1, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 8'hA1, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 8'hA1, 1, 8'hA1, 4'h1, 1, 0));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 8'hA2, 1, 8'hA2, 4'h1, 1, 0));
        tbl.push_back(mk(0, 4'h1, 4'h1, 0, 8'hA3, 1, 8'hA3, 4'h1, 1, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'hA3, 0, 8'h00, 4'h0, 1, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'hA3, 0, 8'h00, 4'h0, 0, 0));
        // All valid, never last: 4 beats each in order 0..3 then 0, no bubbles.
        tbl.push_back(mk(1, 4'hF, 4'h0, 0, 8'h5C, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 8'h5C, 0, 8'h00, 4'h0, 0, 0));
        for (int g = 0; g < 4; g++)
            for (int b = 0; b < 4; b++)
                tbl.push_back(mk(0, 4'hF, 4'h0, 0, 8'h5C, 1, lane5c[g], 4'(1 << g), 1, 2'(g)));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 8'h5C, 1, 8'h5C, 4'h1, 1, 0));
        // Req1 stalls 5 cycles on full after 2 beats, then completes 4 beats.
        tbl.push_back(mk(1, 4'h2, 4'h0, 0, 8'h33, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 8'h33, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 8'h33, 1, 8'h23, 4'h2, 1, 1));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 8'h33, 1, 8'h23, 4'h2, 1, 1));
        for (int s = 0; s < 5; s++)
            tbl.push_back(mk(0, 4'h2, 4'h0, 1, 8'h33, 0, 8'h00, 4'h0, 1, 1));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 8'h33, 1, 8'h23, 4'h2, 1, 1));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 8'h33, 1, 8'h23, 4'h2, 1, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h33, 0, 8'h00, 4'h0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 8'h33, 0, 8'h00, 4'h0, 0, 0));
        // Req2 abandons after one beat; dead cycle, idle, then req3.
        tbl.push_back(mk(1, 4'h4, 4'h0, 0, 8'h90, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 8'h90, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 8'h90, 1, 8'hB0, 4'h4, 1, 2));
        tbl.push_back(mk(0, 4'h8, 4'h0, 0, 8'h90, 0, 8'h00, 4'h0, 1, 2));
        tbl.push_back(mk(0, 4'h8, 4'h0, 0, 8'h90, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h8, 4'h0, 0, 8'h90, 1, 8'hA0, 4'h8, 1, 3));
        // Reset mid-burst of req1; afterwards req0 wins first.
        tbl.push_back(mk(1, 4'h2, 4'h0, 0, 8'h0F, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 8'h0F, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 8'h0F, 1, 8'h1F, 4'h2, 1, 1));
        tbl.push_back(mk(0, 4'h3, 4'h0, 0, 8'h0F, 1, 8'h1F, 4'h2, 1, 1));
        tbl.push_back(mk(1, 4'h3, 4'h0, 0, 8'h0F, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h3, 4'h0, 0, 8'h0F, 0, 8'h00, 4'h0, 0, 0));
        tbl.push_back(mk(0, 4'h3, 4'h0, 0, 8'h0F, 1, 8'h0F, 4'h1, 1, 0));

        foreach (tbl[n]) begin
            @(negedge clk);
            rst       = tbl[n].rst;
            req_valid = tbl[n].valid;
            req_last  = tbl[n].last;
            full      = tbl[n].full;
            req_data  = {tbl[n].dat ^ 8'h30, tbl[n].dat ^ 8'h20, tbl[n].dat ^ 8'h10, tbl[n].dat};
            #1;
            check($sformatf("vec%0d {w_en,data,ready,gv,gid}", n),
                  32'({w_en, data_in, req_ready, grant_valid, grant_id}),
                  32'({tbl[n].w_en, tbl[n].data, tbl[n].ready, tbl[n].gv, tbl[n].gid}));
        end

`ifdef WRARB_STATS_EN
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_last = '0; full = 1'b0;
        #1 check("stat_reset", 32'(stat_beats[47:32]), 32'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 4'h4;
        repeat (11) @(negedge clk);
        req_valid = '0;
        #1 check("stat_ten", 32'(stat_beats[47:32]), 32'd10);
        check("stat_others", 32'({stat_beats[63:48], stat_beats[31:0]} != '0), 32'd0);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        #1 check("stat_clr", 32'(stat_beats[47:32]), 32'd0);
        stat_clr = 1'b0; req_valid = 4'h4;
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        #1 check("stat_clr_wins", 32'(stat_beats[47:32]), 32'd0);
        stat_clr = 1'b0;
        repeat (70000) @(negedge clk);
        #1 check("stat_saturate", 32'(stat_beats[47:32]), 32'h0000FFFF);
        req_valid = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
